// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - CPU-side request and dataMemory-side bus bundle for load_store_unit
interface load_store_unit_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_unsigned;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_err;
  logic        busy;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic [31:0] mem_readData;
  logic        mem_memRead;
  logic        mem_memWrite;

  // LSU view: takes CPU requests and drives dataMemory
  modport slave (
    input  cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata, mem_readData,
    output cpu_rdata, cpu_done, cpu_err, busy,
           mem_address, mem_writeData, mem_memRead, mem_memWrite
  );

  // Environment view: CPU issuing requests plus the dataMemory model
  modport master (
    output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata, mem_readData,
    input  cpu_rdata, cpu_done, cpu_err, busy,
           mem_address, mem_writeData, mem_memRead, mem_memWrite
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit in front of a word-wide dataMemory (optional LSU_ALIGN_CHECK_EN)
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input logic             clk,
  input logic             rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RMW_RD,
    S_RMW_WR,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;
  logic [1:0]  r_size;
  logic        r_uns;
  logic        r_err;

  logic        w_accept;
  logic        w_misalign;
  logic        w_req_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;
  logic [31:0] w_merge;

  // Alignment faults only exist when the check is compiled in; otherwise low bits are truncated
  always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
    w_misalign = ((bus.cpu_size == 2'b01) && bus.cpu_addr[0]) ||
                 ((bus.cpu_size == 2'b10) && (bus.cpu_addr[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
  end

  // Request acceptance and error classification, evaluated on the live CPU inputs
  always_comb begin
    w_accept  = (r_state == S_IDLE) && bus.cpu_req;
    w_req_err = (bus.cpu_size == 2'b11) || (bus.cpu_addr >= MEM_BYTES) || w_misalign;
  end

  // Pick the addressed little-endian lane out of the memory word and extend it
  always_comb begin
    w_byte = 8'h00;
    case (r_addr[1:0])
      2'd0: w_byte = bus.mem_readData[7:0];
      2'd1: w_byte = bus.mem_readData[15:8];
      2'd2: w_byte = bus.mem_readData[23:16];
      default: w_byte = bus.mem_readData[31:24];
    endcase
    w_half = r_addr[1] ? bus.mem_readData[31:16] : bus.mem_readData[15:0];
    case (r_size)
      2'b00:   w_load_ext = r_uns ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = r_uns ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_ext = bus.mem_readData;
    endcase
  end

  // Read-modify-write merge: keep the memory word, overwrite only the target lane
  always_comb begin
    w_merge = bus.mem_readData;
    if (r_size == 2'b00) begin
      case (r_addr[1:0])
        2'd0: w_merge[7:0]   = r_wdata[7:0];
        2'd1: w_merge[15:8]  = r_wdata[7:0];
        2'd2: w_merge[23:16] = r_wdata[7:0];
        default: w_merge[31:24] = r_wdata[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_merge[31:16] = r_wdata[15:0];
    end else begin
      w_merge[15:0]  = r_wdata[15:0];
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode plus state-only strobes so memRead/memWrite can never overlap
  always_comb begin
    w_next            = r_state;
    bus.busy          = (r_state != S_IDLE);
    bus.cpu_done      = 1'b0;
    bus.mem_memRead   = 1'b0;
    bus.mem_memWrite  = 1'b0;
    bus.mem_writeData = 32'h0;
    bus.mem_address   = {r_addr[31:2], 2'b00};
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err)               w_next = S_DONE;
          else if (!bus.cpu_we)        w_next = S_LOAD;
          else if (bus.cpu_size == 2'b10) w_next = S_WRITE;
          else                         w_next = S_RMW_RD;
        end
      end
      S_LOAD: begin
        bus.mem_memRead = 1'b1;
        w_next          = S_DONE;
      end
      S_WRITE: begin
        bus.mem_memWrite  = 1'b1;
        bus.mem_writeData = r_wdata;
        w_next            = S_DONE;
      end
      S_RMW_RD: begin
        bus.mem_memRead = 1'b1;
        w_next          = S_RMW_WR;
      end
      S_RMW_WR: begin
        bus.mem_memWrite  = 1'b1;
        bus.mem_writeData = r_merge;
        w_next            = S_DONE;
      end
      S_DONE: begin
        bus.cpu_done = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch on acceptance, load result capture, and RMW merge capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
      r_merge <= 32'h0;
    end else begin
      if (w_accept) begin
        r_addr  <= bus.cpu_addr;
        r_wdata <= bus.cpu_wdata;
        r_size  <= bus.cpu_size;
        r_uns   <= bus.cpu_unsigned;
        r_err   <= w_req_err;
      end
      if (r_state == S_LOAD)   r_rdata <= w_load_ext;
      if (r_state == S_RMW_RD) r_merge <= w_merge;
    end
  end

  // Registered CPU results
  always_comb begin
    bus.cpu_rdata = r_rdata;
    bus.cpu_err   = r_err;
  end

endmodule
